// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcodes, field widths and the encode/writer state.
// Imported by the IR encoder writer and its word FIFO.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_imm4;
  typedef logic [4:0]  lc3b_imm5;
  typedef logic [5:0]  lc3b_offset6;
  typedef logic [8:0]  lc3b_offset9;
  typedef logic [10:0] lc3b_offset11;
  typedef logic [7:0]  lc3b_byte;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  localparam int ENC_FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } lc3b_enc_state_t;

endpackage

// File: rtl/ir_word_fifo.sv
// Synchronous word FIFO between the encoder handshake and the memory writer.
// Ports: clk, reset, push/wdata in, pop in, head/full/empty/count out.
import lc3b_types::*;

module ir_word_fifo #(
  parameter int DEPTH = ENC_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [15:0]   wdata,
  input  logic          pop,
  output logic [15:0]   head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          wr_en;
  logic          rd_en;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ir_encoder_writer.sv
// Packs LC-3b instruction fields into words, buffers them and writes them
// to sequential word addresses. Ports: encode handshake + fields, memory port, status.
import lc3b_types::*;

module ir_encoder_writer #(
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int          FIFO_DEPTH = ENC_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enc_valid,
  output logic        enc_ready,
  input  logic [3:0]  opcode,
  input  logic [2:0]  dest,
  input  logic [2:0]  src1,
  input  logic [2:0]  src2,
  input  logic [5:0]  offset6,
  input  logic [8:0]  offset9,
  input  logic [10:0] offset11,
  input  logic [4:0]  imm5,
  input  logic [3:0]  imm4,
  input  logic        imm_bool,
  input  logic        jsr_bool,
  input  logic        shift_bool,
  input  logic [7:0]  trapvect,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  input  logic        mem_resp,
  output logic        busy,
  output logic [15:0] words_written
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  lc3b_opcode      op;
  lc3b_word        enc_word;
  lc3b_word        head;
  lc3b_enc_state_t state;
  lc3b_enc_state_t state_nx;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [15:0]     addr;
  logic [15:0]     wcount;

  assign op = lc3b_opcode'(opcode);

  always_comb begin
    enc_word = {opcode, 12'h000};
    unique case (op)
      op_add, op_and:
        enc_word[11:0] = imm_bool ? {dest, src1, 1'b1, imm5}
                                  : {dest, src1, 3'b000, src2};
      op_not:
        enc_word[11:0] = {dest, src1, 6'h3F};
      op_br, op_lea:
        enc_word[11:0] = {dest, offset9};
      op_jmp:
        enc_word[11:0] = {3'b000, src1, 6'h00};
      op_jsr:
        enc_word[11:0] = jsr_bool ? {1'b1, offset11}
                                  : {3'b000, src1, 6'h00};
      op_ldb, op_stb, op_ldr, op_str, op_ldi, op_sti:
        enc_word[11:0] = {dest, src1, offset6};
      op_shf:
        enc_word[11:0] = {dest, src1, imm_bool, shift_bool, imm4};
      op_trap:
        enc_word[11:0] = {4'h0, trapvect};
      op_rti:
        enc_word[11:0] = 12'h000;
      default:
        enc_word[11:0] = 12'h000;
    endcase
  end

  // Ready depends only on full: a pop in the same cycle does not free a slot.
  assign enc_ready = !full;
  assign push      = enc_valid && enc_ready;
  assign pop       = mem_write && mem_resp;

  ir_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (enc_word),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A push is looked at directly so the write starts the cycle after it.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!empty || push) begin
          state_nx = WRITE;
        end
      end
      WRITE: begin
        if (mem_resp) begin
          state_nx = (push || count > CW'(1)) ? WRITE : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr   <= BASE_ADDR;
      wcount <= 16'h0000;
    end else if (pop) begin
      addr   <= addr + 16'd2;
      wcount <= wcount + 16'd1;
    end
  end

  assign mem_write       = (state == WRITE);
  assign mem_address     = addr;
  assign mem_wdata       = mem_write ? head : 16'h0000;
  assign mem_byte_enable = mem_write ? 2'b11 : 2'b00;
  assign busy            = !empty || mem_write;
  assign words_written   = wcount;

endmodule

// File: tb/tb_ir_encoder_writer.sv
// Randomized bench for ir_encoder_writer against a queue-based model.
// Two instances share stimulus: base 0000 and base FFFE (address wrap).
module tb_ir_encoder_writer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [2:0]  dest;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic [5:0]  off6;
    logic [8:0]  off9;
    logic [10:0] off11;
    logic [4:0]  imm5;
    logic [3:0]  imm4;
    logic        imm_b;
    logic        jsr_b;
    logic        shf_b;
    logic [7:0]  trap;
  } fields_t;

  logic        clk;
  logic        reset;
  logic        enc_valid;
  logic [3:0]  opcode;
  logic [2:0]  dest;
  logic [2:0]  src1;
  logic [2:0]  src2;
  logic [5:0]  offset6;
  logic [8:0]  offset9;
  logic [10:0] offset11;
  logic [4:0]  imm5;
  logic [3:0]  imm4;
  logic        imm_bool;
  logic        jsr_bool;
  logic        shift_bool;
  logic [7:0]  trapvect;
  logic        mem_resp;

  logic        a_ready, b_ready;
  logic [15:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_write, b_write;
  logic [1:0]  a_be, b_be;
  logic        a_busy, b_busy;
  logic [15:0] a_ww, b_ww;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q[$];
  int          ww;
  logic [15:0] la_addr[$];
  logic [15:0] la_data[$];
  logic [15:0] lb_addr[$];

  ir_encoder_writer #(
    .BASE_ADDR (16'h0000),
    .FIFO_DEPTH(DEPTH)
  ) ua (
    .clk(clk), .reset(reset),
    .enc_valid(enc_valid), .enc_ready(a_ready),
    .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
    .offset6(offset6), .offset9(offset9), .offset11(offset11),
    .imm5(imm5), .imm4(imm4), .imm_bool(imm_bool),
    .jsr_bool(jsr_bool), .shift_bool(shift_bool), .trapvect(trapvect),
    .mem_address(a_addr), .mem_wdata(a_wdata), .mem_write(a_write),
    .mem_byte_enable(a_be), .mem_resp(mem_resp),
    .busy(a_busy), .words_written(a_ww)
  );

  ir_encoder_writer #(
    .BASE_ADDR (16'hFFFE),
    .FIFO_DEPTH(DEPTH)
  ) ub (
    .clk(clk), .reset(reset),
    .enc_valid(enc_valid), .enc_ready(b_ready),
    .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
    .offset6(offset6), .offset9(offset9), .offset11(offset11),
    .imm5(imm5), .imm4(imm4), .imm_bool(imm_bool),
    .jsr_bool(jsr_bool), .shift_bool(shift_bool), .trapvect(trapvect),
    .mem_address(b_addr), .mem_wdata(b_wdata), .mem_write(b_write),
    .mem_byte_enable(b_be), .mem_resp(mem_resp),
    .busy(b_busy), .words_written(b_ww)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_encode(fields_t f);
    logic [11:0] lo;
    case (f.opcode)
      4'h1, 4'h5:
        lo = f.imm_b ? {f.dest, f.src1, 1'b1, f.imm5}
                     : {f.dest, f.src1, 3'b000, f.src2};
      4'h9: lo = {f.dest, f.src1, 6'h3F};
      4'h0, 4'hE: lo = {f.dest, f.off9};
      4'hC: lo = {3'b000, f.src1, 6'h00};
      4'h4:
        lo = f.jsr_b ? {1'b1, f.off11}
                     : {3'b000, f.src1, 6'h00};
      4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB:
        lo = {f.dest, f.src1, f.off6};
      4'hD: lo = {f.dest, f.src1, f.imm_b, f.shf_b, f.imm4};
      4'hF: lo = {4'h0, f.trap};
      default: lo = 12'h000;
    endcase
    return {f.opcode, lo};
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f.opcode = 4'($urandom);
    f.dest   = 3'($urandom);
    f.src1   = 3'($urandom);
    f.src2   = 3'($urandom);
    f.off6   = 6'($urandom);
    f.off9   = 9'($urandom);
    f.off11  = 11'($urandom);
    f.imm5   = 5'($urandom);
    f.imm4   = 4'($urandom);
    f.imm_b  = 1'($urandom);
    f.jsr_b  = 1'($urandom);
    f.shf_b  = 1'($urandom);
    f.trap   = 8'($urandom);
    return f;
  endfunction

  task automatic apply(fields_t f);
    opcode     = f.opcode;
    dest       = f.dest;
    src1       = f.src1;
    src2       = f.src2;
    offset6    = f.off6;
    offset9    = f.off9;
    offset11   = f.off11;
    imm5       = f.imm5;
    imm4       = f.imm4;
    imm_bool   = f.imm_b;
    jsr_bool   = f.jsr_b;
    shift_bool = f.shf_b;
    trapvect   = f.trap;
  endtask

  task automatic verify_one(
    string n, logic [15:0] base,
    logic rdy, logic wr, logic bsy,
    logic [15:0] wwv, logic [15:0] wd,
    logic [15:0] ad, logic [1:0] be
  );
    logic [15:0] exp_addr;
    exp_addr = base + 16'(2 * ww);
    check({n, "_ready"}, 32'(rdy), 32'(q.size() < DEPTH));
    check({n, "_write"}, 32'(wr), 32'(q.size() != 0));
    check({n, "_busy"}, 32'(bsy), 32'(q.size() != 0));
    check({n, "_count"}, 32'(wwv), 32'(ww[15:0]));
    if (q.size() != 0) begin
      check({n, "_wdata"}, 32'(wd), 32'(q[0]));
      check({n, "_addr"}, 32'(ad), 32'(exp_addr));
      check({n, "_be"}, 32'(be), 32'h3);
    end else begin
      check({n, "_be_idle"}, 32'(be), 32'h0);
    end
  endtask

  // Caller sits just after a negedge; the model advances as the next posedge will.
  task automatic step(bit v, fields_t f, bit r, bit rst);
    bit full;
    reset     = rst;
    enc_valid = v;
    mem_resp  = r;
    apply(f);
    if (rst) begin
      q.delete();
      ww = 0;
    end else begin
      full = (q.size() >= DEPTH);
      if (q.size() != 0 && r) begin
        la_addr.push_back(a_addr);
        la_data.push_back(a_wdata);
        lb_addr.push_back(b_addr);
        void'(q.pop_front());
        ww = (ww + 1) & 16'hFFFF;
      end
      if (v && !full) begin
        q.push_back(ref_encode(f));
      end
    end
    @(posedge clk);
    @(negedge clk);
    verify_one("a", 16'h0000, a_ready, a_write, a_busy,
               a_ww, a_wdata, a_addr, a_be);
    verify_one("b", 16'hFFFE, b_ready, b_write, b_busy,
               b_ww, b_wdata, b_addr, b_be);
  endtask

  task automatic reset_checks(string n);
    check({n, "_rst_addr_a"}, 32'(a_addr), 32'h0000);
    check({n, "_rst_addr_b"}, 32'(b_addr), 32'hFFFE);
    check({n, "_rst_wdata"}, 32'(a_wdata), 32'h0000);
    check({n, "_rst_write"}, 32'(a_write), 32'h0);
    check({n, "_rst_busy"}, 32'(a_busy), 32'h0);
    check({n, "_rst_ww"}, 32'(a_ww), 32'h0);
    check({n, "_rst_ready"}, 32'(a_ready), 32'h1);
  endtask

  fields_t f0;
  fields_t dv[6];
  fields_t f5;
  logic [15:0] dexp[6];

  initial begin
    f0 = '0;
    ww = 0;
    reset = 1'b1;
    enc_valid = 1'b0;
    mem_resp = 1'b0;
    apply(f0);

    step(1'b0, f0, 1'b0, 1'b1);
    step(1'b0, f0, 1'b0, 1'b1);
    step(1'b0, f0, 1'b0, 1'b0);
    reset_checks("init");

    for (int i = 0; i < 6; i++) dv[i] = rand_fields();
    dv[0].opcode = 4'h1; dv[0].dest = 3'd1; dv[0].src1 = 3'd2;
    dv[0].imm_b = 1'b1; dv[0].imm5 = 5'h1D;
    dv[1].opcode = 4'h9; dv[1].dest = 3'd3; dv[1].src1 = 3'd4;
    dv[2].opcode = 4'hF; dv[2].trap = 8'h25;
    dv[3].opcode = 4'h4; dv[3].jsr_b = 1'b1; dv[3].off11 = 11'h7FF;
    dv[4].opcode = 4'h0; dv[4].dest = 3'd7; dv[4].off9 = 9'h1FF;
    dv[5].opcode = 4'hD; dv[5].dest = 3'd1; dv[5].src1 = 3'd1;
    dv[5].imm_b = 1'b1; dv[5].shf_b = 1'b1; dv[5].imm4 = 4'd3;
    dexp[0] = 16'h12BD; dexp[1] = 16'h973F; dexp[2] = 16'hF025;
    dexp[3] = 16'h4FFF; dexp[4] = 16'h0FFF; dexp[5] = 16'hD273;

    step(1'b1, dv[0], 1'b0, 1'b0);
    check("add_wdata", 32'(a_wdata), 32'h12BD);
    check("add_be", 32'(a_be), 32'h3);
    for (int i = 1; i < 6; i++) step(1'b1, dv[i], 1'b1, 1'b0);
    for (int k = 0; k < 10 && q.size() != 0; k++) begin
      step(1'b0, f0, 1'b1, 1'b0);
    end
    check("dir_len", 32'(la_data.size()), 32'd6);
    for (int i = 0; i < 6 && i < la_data.size(); i++) begin
      check($sformatf("dir_word%0d", i), 32'(la_data[i]), 32'(dexp[i]));
      check($sformatf("dir_addr%0d", i), 32'(la_addr[i]), 32'(2 * i));
    end
    if (lb_addr.size() >= 2) begin
      check("wrap_addr0", 32'(lb_addr[0]), 32'hFFFE);
      check("wrap_addr1", 32'(lb_addr[1]), 32'h0000);
    end else begin
      check("wrap_len", 32'(lb_addr.size()), 32'd2);
    end
    check("dir_ww", 32'(b_ww), 32'd6);
    check("dir_busy", 32'(b_busy), 32'h0);

    for (int i = 0; i < DEPTH; i++) step(1'b1, rand_fields(), 1'b0, 1'b0);
    check("full_ready", 32'(a_ready), 32'h0);
    f5 = rand_fields();
    step(1'b1, f5, 1'b0, 1'b0);
    step(1'b1, f5, 1'b0, 1'b0);
    step(1'b1, f5, 1'b1, 1'b0);
    check("pop_full_ready", 32'(a_ready), 32'h1);
    step(1'b1, f5, 1'b0, 1'b0);
    check("refill_ready", 32'(a_ready), 32'h0);
    for (int k = 0; k < 12 && q.size() != 0; k++) begin
      step(1'b0, f0, 1'b1, 1'b0);
    end

    step(1'b1, rand_fields(), 1'b0, 1'b0);
    check("pre_rst_write", 32'(a_write), 32'h1);
    step(1'b0, f0, 1'b0, 1'b1);
    reset_checks("mid");
    step(1'b0, f0, 1'b1, 1'b0);

    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 9) < 6, rand_fields(),
           $urandom_range(0, 9) < 4, $urandom_range(0, 299) == 0);
    end
    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      step(1'b0, f0, 1'b1, 1'b0);
    end
    check("drain_model", 32'(q.size()), 32'd0);
    check("drain_busy", 32'(a_busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
